// File: rtl/seven_seg_display_driver.sv
// Seven-segment driver fed by a 4-digit anode scanner. The display value is double-buffered and
// promoted only on entry to digit 0, so a scan frame never shows a torn value.
module seven_seg_display_driver #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  anode_out,
  output logic        pending,
  output logic        frame_done
);

  localparam logic [6:0] SegOff  = 7'h7F;
  localparam logic [3:0] AnOff   = 4'hF;
  localparam logic [3:0] Digit0  = 4'b1110;
  // XOR masks applied at the output register; zero when the board is active-low.
  localparam logic [6:0] SegMask = ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic       DpMask  = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic [3:0] AnMask  = ACTIVE_LOW ? 4'h0 : 4'hF;

  logic [3:0]  prev_anode_q;
  logic        boundary;

  logic [15:0] shadow_value_q, shadow_value_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        shadow_blz_q, shadow_blz_d;
  logic [15:0] active_value_q, active_value_d;
  logic [3:0]  active_dp_q, active_dp_d;
  logic        active_blz_q, active_blz_d;
  logic        pending_q, pending_d;
  logic        frame_done_q;

  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  anode_out_q, anode_out_d;

  logic        sel_valid;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic        dp_bit;
  logic        blank;
  logic        lz3, lz2, lz1;
  logic [6:0]  seg_raw;
  logic        dp_raw;
  logic [3:0]  an_raw;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign boundary = (anode == Digit0) && (prev_anode_q != Digit0);

  // Shadow/active buffering; a load on the boundary cycle bypasses the shadow.
  always_comb begin
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blz_d   = shadow_blz_q;
    active_value_d = active_value_q;
    active_dp_d    = active_dp_q;
    active_blz_d   = active_blz_q;
    pending_d      = pending_q;
    if (load) begin
      shadow_value_d = value_in;
      shadow_dp_d    = dp_in;
      shadow_blz_d   = blank_lz;
      pending_d      = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        active_value_d = value_in;
        active_dp_d    = dp_in;
        active_blz_d   = blank_lz;
      end else if (pending_q) begin
        active_value_d = shadow_value_q;
        active_dp_d    = shadow_dp_q;
        active_blz_d   = shadow_blz_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    sel_valid = 1'b1;
    sel       = 2'd0;
    case (anode)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  // Decode uses the next active value so a same-edge promotion is visible immediately.
  always_comb begin
    lz3 = (active_value_d[15:12] == 4'h0);
    lz2 = lz3 && (active_value_d[11:8] == 4'h0);
    lz1 = lz2 && (active_value_d[7:4] == 4'h0);
    nibble = active_value_d[3:0];
    blank  = 1'b0;
    case (sel)
      2'd0: nibble = active_value_d[3:0];
      2'd1: begin
        nibble = active_value_d[7:4];
        blank  = lz1;
      end
      2'd2: begin
        nibble = active_value_d[11:8];
        blank  = lz2;
      end
      default: begin
        nibble = active_value_d[15:12];
        blank  = lz3;
      end
    endcase
    blank  = blank && active_blz_d;
    dp_bit = active_dp_d[sel];
  end

  always_comb begin
    seg_raw = SegOff;
    dp_raw  = 1'b1;
    an_raw  = AnOff;
    if (sel_valid) begin
      seg_raw = blank ? SegOff : hex_decode(nibble);
      dp_raw  = ~dp_bit;
      an_raw  = anode;
    end
    seg_d       = seg_raw ^ SegMask;
    dp_d        = dp_raw ^ DpMask;
    anode_out_d = an_raw ^ AnMask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_anode_q   <= AnOff;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blz_q   <= 1'b0;
      active_value_q <= '0;
      active_dp_q    <= '0;
      active_blz_q   <= 1'b0;
      pending_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      seg_q          <= SegOff ^ SegMask;
      dp_q           <= 1'b1 ^ DpMask;
      anode_out_q    <= AnOff ^ AnMask;
    end else begin
      prev_anode_q   <= anode;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blz_q   <= shadow_blz_d;
      active_value_q <= active_value_d;
      active_dp_q    <= active_dp_d;
      active_blz_q   <= active_blz_d;
      pending_q      <= pending_d;
      frame_done_q   <= boundary;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      anode_out_q    <= anode_out_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign anode_out  = anode_out_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Scoreboard bench for seven_seg_display_driver: expected seg/dp/anode_out are queued as
// stimulus is driven and popped one clock later; scenario tasks check pending/frame_done inline.
module tb_seven_seg_display_driver;

  localparam logic [6:0] OFF = 7'h7F;
  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode_out;
  logic        pending;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  seven_seg_display_driver dut (
    .clk        (clk),
    .reset      (reset),
    .anode      (anode),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .anode_out  (anode_out),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({seg, dp, anode_out} !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t seg/dp/anode_out got %b/%b/%b want %b/%b/%b", $time,
                 seg, dp, anode_out, mon_e.seg, mon_e.dp, mon_e.an);
      end
    end
  end

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic one_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  task automatic step(input logic [3:0] an, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic blz, input logic [6:0] es,
                      input logic edp);
    exp_t e;
    @(negedge clk);
    anode    = an;
    load     = ld;
    value_in = v;
    dp_in    = d;
    blank_lz = blz;
    e.seg = es;
    e.dp  = edp;
    e.an  = one_low(an) ? an : 4'hF;
    sb.push_back(e);
  endtask

  // One full scan starting with a fresh entry to digit 0 and no load.
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] dps, input int hold);
    logic [6:0] s [4];
    int fd;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    fd = 0;
    for (int d = 0; d < 4; d++) begin
      for (int h = 0; h < hold; h++) begin
        step(an_of(d), 1'b0, 16'h0, 4'h0, 1'b0, s[d], ~dps[d]);
        @(posedge clk); #1;
        fd += int'(frame_done);
        if (d == 0 && h == 0) begin
          checks++;
          if (frame_done !== 1'b1 || pending !== 1'b0) begin
            errors++;
            $display("FAIL frame_start frame_done/pending got %b/%b want 1/0", frame_done, pending);
          end
        end
      end
    end
    checks++;
    if (fd != 1) begin
      errors++;
      $display("FAIL frame_done_count got %0d want 1", fd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; anode = 4'hF; load = 1'b0; value_in = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({seg, dp, anode_out, pending, frame_done} !== {OFF, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state seg/dp/an/pend/fd got %b/%b/%b/%b/%b want %b/1/1111/0/0",
               seg, dp, anode_out, pending, frame_done, OFF);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_zero_scan();
    run_frame(DEC[0], DEC[0], DEC[0], DEC[0], 4'h0, 4);
    run_frame(DEC[0], DEC[0], DEC[0], DEC[0], 4'h0, 4);
  endtask

  task automatic test_load_pending();
    for (int d = 0; d < 4; d++) begin
      for (int h = 0; h < 4; h++) begin
        step(an_of(d), (d == 2 && h == 0), 16'h12AF, 4'h0, 1'b0, DEC[0], 1'b1);
        if (d == 2 && h == 0) begin
          @(posedge clk); #1;
          checks++;
          if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pending_after_load got %b want 1", pending);
          end
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_held got %b want 1", pending);
    end
    run_frame(DEC[15], DEC[10], DEC[2], DEC[1], 4'h0, 4);
  endtask

  task automatic test_last_wins();
    logic [6:0] cur [4];
    cur[0] = DEC[15]; cur[1] = DEC[10]; cur[2] = DEC[2]; cur[3] = DEC[1];
    for (int d = 0; d < 4; d++) begin
      for (int h = 0; h < 3; h++) begin
        if (d == 1 && h == 0)
          step(an_of(d), 1'b1, 16'h0000, 4'h0, 1'b0, cur[d], 1'b1);
        else if (d == 2 && h == 0)
          step(an_of(d), 1'b1, 16'h00C5, 4'h0, 1'b1, cur[d], 1'b1);
        else
          step(an_of(d), 1'b0, 16'h0, 4'h0, 1'b0, cur[d], 1'b1);
      end
    end
    run_frame(DEC[5], DEC[12], OFF, OFF, 4'h0, 3);
  endtask

  task automatic test_coincident();
    step(4'b1110, 1'b1, 16'h8888, 4'b0001, 1'b0, DEC[8], 1'b0);
    @(posedge clk); #1;
    checks++;
    if (pending !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL coincident_load pending/frame_done got %b/%b want 0/1", pending, frame_done);
    end
    for (int h = 0; h < 3; h++) step(4'b1110, 1'b0, 16'h0, 4'h0, 1'b0, DEC[8], 1'b0);
    for (int d = 1; d < 4; d++)
      for (int h = 0; h < 4; h++) step(an_of(d), 1'b0, 16'h0, 4'h0, 1'b0, DEC[8], 1'b1);
  endtask

  task automatic test_invalid();
    step(4'b1100, 1'b0, 16'h0, 4'h0, 1'b0, OFF, 1'b1);
    step(4'hF, 1'b0, 16'h0, 4'h0, 1'b0, OFF, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL invalid_no_boundary frame_done got %b want 0", frame_done);
    end
    step(4'b1110, 1'b0, 16'h0, 4'h0, 1'b0, DEC[8], 1'b0);
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL boundary_from_blank frame_done got %b want 1", frame_done);
    end
  endtask

  task automatic test_reset_mid();
    int fd;
    step(4'b1101, 1'b0, 16'h0, 4'h0, 1'b0, DEC[8], 1'b1);
    step(4'b1011, 1'b0, 16'h0, 4'h0, 1'b0, DEC[8], 1'b1);
    step(4'b0111, 1'b1, 16'h1234, 4'hF, 1'b0, DEC[8], 1'b1);
    @(posedge clk); #1;
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_before_reset got %b want 1", pending);
    end
    #2;
    reset = 1'b0;
    load  = 1'b0;
    #1;
    checks++;
    if ({seg, dp, anode_out, pending, frame_done} !== {OFF, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset seg/dp/an/pend/fd got %b/%b/%b/%b/%b want %b/1/1111/0/0",
               seg, dp, anode_out, pending, frame_done, OFF);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    anode = 4'hF;
    fd = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1110, 1'b0, 16'h0, 4'h0, 1'b0, DEC[0], 1'b1);
      @(posedge clk); #1;
      fd += int'(frame_done);
    end
    checks++;
    if (fd != 1) begin
      errors++;
      $display("FAIL held_digit0_after_reset frame_done count got %0d want 1", fd);
    end
  endtask

  initial begin
    test_reset();
    test_zero_scan();
    test_load_pending();
    test_last_wins();
    test_coincident();
    test_invalid();
    test_reset_mid();
    @(posedge clk); #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
